// File: rtl/stream_join.sv
// Two-channel synchronising join: each channel buffers up to two words and
// the consumer sees {A_head, B_head} once both channels hold data.

module stream_join_ch #(
  parameter int iw = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enq,
  input  logic [iw-1:0] d,
  input  logic          deq_ok,
  output logic          full_n,
  output logic          nonempty,
  output logic          ovf,
  output logic [iw-1:0] head
);
  logic [1:0]    cnt;
  logic [iw-1:0] head_q, tail_q;
  logic          enq_ok;

  assign full_n   = (cnt != 2'd2);
  assign nonempty = (cnt != 2'd0);
  assign enq_ok   = enq && full_n;
  assign ovf      = enq && !full_n;
  assign head     = head_q;

  // deq_ok implies cnt >= 1, so the enq+deq case never sees an empty channel
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({deq_ok, enq_ok})
        2'b11: begin
          if (cnt == 2'd2) begin
            head_q <= tail_q;
            tail_q <= d;
          end else begin
            head_q <= d;
          end
        end
        2'b10: begin
          if (cnt == 2'd2) head_q <= tail_q;
          cnt <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) head_q <= d;
          else             tail_q <= d;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  a_cnt_range: assert property (@(posedge CLK) disable iff (RST) cnt != 2'd3);
endmodule

module stream_join #(
  parameter int iw = 1,
  parameter int ow = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENQ_A,
  input  logic [iw-1:0] D_A,
  output logic          FULL_N_A,
  input  logic          ENQ_B,
  input  logic [iw-1:0] D_B,
  output logic          FULL_N_B,
  input  logic          DEQ,
  output logic [ow-1:0] D_OUT,
  output logic          EMPTY_N,
  output logic          ERR
);
  localparam int NUM_CH = 2;

  generate
    if (ow != 2 * iw) begin : g_bad_ow
      $error("stream_join: ow must equal 2*iw");
    end
  endgenerate

  // Channel 1 is A, channel 0 is B, so the packed head array is {A, B}
  logic [NUM_CH-1:0]         enq, full_n, nonempty, ovf;
  logic [NUM_CH-1:0][iw-1:0] din, head;
  logic                      deq_ok, err_q;

  assign enq     = {ENQ_A, ENQ_B};
  assign din     = {D_A, D_B};
  assign EMPTY_N = &nonempty;
  assign deq_ok  = DEQ && EMPTY_N;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      stream_join_ch #(.iw(iw)) u_ch (
        .CLK      (CLK),
        .RST      (RST),
        .enq      (enq[g]),
        .d        (din[g]),
        .deq_ok   (deq_ok),
        .full_n   (full_n[g]),
        .nonempty (nonempty[g]),
        .ovf      (ovf[g]),
        .head     (head[g])
      );
    end
  endgenerate

  assign FULL_N_A = full_n[1];
  assign FULL_N_B = full_n[0];
  assign D_OUT    = head;
  assign ERR      = err_q;

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_q | (|ovf) | (DEQ && !EMPTY_N);
  end
endmodule

// File: tb/tb_stream_join.sv
// Randomized and directed bench for stream_join with a queue-based model.
module tb_stream_join;
  localparam int IW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq_a = 1'b0, enq_b = 1'b0, deq = 1'b0;
  logic [IW-1:0] d_a = '0, d_b = '0;
  logic          full_n_a, full_n_b, empty_n, err;
  logic [OW-1:0] d_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [IW-1:0] qa[$];
  logic [IW-1:0] qb[$];
  bit            m_err = 1'b0;

  stream_join #(.iw(IW), .ow(OW)) dut (
    .CLK(clk), .RST(rst),
    .ENQ_A(enq_a), .D_A(d_a), .FULL_N_A(full_n_a),
    .ENQ_B(enq_b), .D_B(d_b), .FULL_N_B(full_n_b),
    .DEQ(deq), .D_OUT(d_out), .EMPTY_N(empty_n), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two FIFOs of words plus a sticky error bit
  always @(posedge clk) begin
    int  na, nb;
    bit  dok;
    na = qa.size();
    nb = qb.size();
    if (rst) begin
      qa.delete();
      qb.delete();
      m_err = 1'b0;
    end else begin
      dok = deq && na > 0 && nb > 0;
      if ((enq_a && na == 2) || (enq_b && nb == 2) || (deq && !dok)) m_err = 1'b1;
      if (dok) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (enq_a && na != 2) qa.push_back(d_a);
      if (enq_b && nb != 2) qb.push_back(d_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("full_n_a", 32'(full_n_a), 32'(qa.size() != 2));
      chk("full_n_b", 32'(full_n_b), 32'(qb.size() != 2));
      chk("empty_n",  32'(empty_n),  32'(qa.size() > 0 && qb.size() > 0));
      chk("err",      32'(err),      32'(m_err));
      if (qa.size() > 0 && qb.size() > 0)
        chk("d_out", 32'(d_out), 32'({qa[0], qb[0]}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_a = 1'b0; enq_b = 1'b0; deq = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst full_n_a", 32'(full_n_a), 32'd1);
    chk("rst full_n_b", 32'(full_n_b), 32'd1);
    chk("rst empty_n",  32'(empty_n),  32'd0);
    chk("rst d_out",    32'(d_out),    32'd0);
    chk("rst err",      32'(err),      32'd0);

    // Latency: A at t0, B at t3
    enq_a = 1'b1; d_a = 8'h11; tick(); idle();
    chk("lat empty_t1", 32'(empty_n), 32'd0);
    tick(); tick();
    enq_b = 1'b1; d_b = 8'h22;
    chk("lat empty_t3", 32'(empty_n), 32'd0);
    tick(); idle();
    chk("lat empty_t4", 32'(empty_n), 32'd1);
    chk("lat d_out_t4", 32'(d_out), 32'h1122);
    deq = 1'b1; tick(); idle();
    chk("lat empty_t5", 32'(empty_n), 32'd0);

    // Full boundary on A
    enq_a = 1'b1; d_a = 8'hA0; enq_b = 1'b1; d_b = 8'hB0; tick();
    enq_b = 1'b0; d_a = 8'hA1; tick(); idle();
    chk("full full_n_a", 32'(full_n_a), 32'd0);
    chk("full full_n_b", 32'(full_n_b), 32'd1);
    enq_a = 1'b1; d_a = 8'hA2; tick(); idle();
    chk("full err", 32'(err), 32'd1);
    enq_b = 1'b1; d_b = 8'hB1; tick(); idle();
    chk("full d_out0", 32'(d_out), 32'hA0B0);
    deq = 1'b1; tick();
    chk("full d_out1", 32'(d_out), 32'hA1B1);
    tick(); idle();
    chk("full drained", 32'(empty_n), 32'd0);
    do_reset();
    chk("full err_clr", 32'(err), 32'd0);

    // Streaming: enq both + deq every cycle
    enq_a = 1'b1; enq_b = 1'b1; d_a = 8'd0; d_b = 8'd0; tick();
    deq = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (i % 25 == 0) chk("stream d_out", 32'(d_out), 32'({8'(i - 1), 8'(i - 1)}));
      d_a = 8'(i); d_b = 8'(i);
      tick();
    end
    idle();
    chk("stream err", 32'(err), 32'd0);
    do_reset();

    // Empty boundary: DEQ with only A holding data
    enq_a = 1'b1; d_a = 8'h55; tick(); idle();
    deq = 1'b1; tick(); idle();
    chk("empty err", 32'(err), 32'd1);
    chk("empty full_n_a", 32'(full_n_a), 32'd1);
    enq_b = 1'b1; d_b = 8'h66; tick(); idle();
    chk("empty d_out", 32'(d_out), 32'h5566);

    // Reset wins over in-flight traffic with both channels full
    do_reset();
    enq_a = 1'b1; enq_b = 1'b1; d_a = 8'h01; d_b = 8'h02; tick();
    d_a = 8'h03; d_b = 8'h04; tick();
    deq = 1'b1; rst = 1'b1; tick(); idle();
    chk("rstwin empty_n",  32'(empty_n),  32'd0);
    chk("rstwin full_n_a", 32'(full_n_a), 32'd1);
    chk("rstwin full_n_b", 32'(full_n_b), 32'd1);
    chk("rstwin err",      32'(err),      32'd0);
    chk("rstwin d_out",    32'(d_out),    32'd0);

    // Random traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      enq_a = ($urandom_range(0, 99) < 60);
      enq_b = ($urandom_range(0, 99) < 60);
      deq   = ($urandom_range(0, 99) < 55);
      rst   = ($urandom_range(0, 99) < 2);
      d_a   = 8'($urandom);
      d_b   = 8'($urandom);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_join.md
Name: stream_join

Overview:
- Two-input synchronising join; the inverse of the team's duplicating fork.
- Two independent producer channels, A and B, each enqueue into a private 2-entry buffer.
- The block presents the concatenation {A_head, B_head} as a single output word once both buffers hold data.
- A single consumer dequeue pops both heads together.
- Sits between parallel producer pipelines and a single-stream consumer, using the codebase's ENQ/FULL_N and DEQ/EMPTY_N FIFO handshake.

Parameters:
iw, 1, width of each input word (A and B)
ow, 2, output word width; must equal 2*iw (elaboration error otherwise)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
ENQ_A  input  1  enqueue strobe, channel A
D_A  input  iw  data, channel A
FULL_N_A  output  1  high when channel A can accept a word
ENQ_B  input  1  enqueue strobe, channel B
D_B  input  iw  data, channel B
FULL_N_B  output  1  high when channel B can accept a word
DEQ  input  1  dequeue strobe; pops one word from each channel
D_OUT  output  ow  {A_head, B_head}; A in the upper iw bits
EMPTY_N  output  1  high when both channels hold at least one word
ERR  output  1  sticky protocol-error flag

Behaviour:
- Interface (already decided): one clock CLK; reset RST is synchronous and active-high.
- Per-channel storage: 2-entry FIFO with a count in {0,1,2}, a head register and a tail register. FIFO ordering within each channel.
- Pairing: the k-th word accepted on A is always paired with the k-th word accepted on B.
- Flags: FULL_N_x = (count_x != 2); EMPTY_N = (count_A != 0) && (count_B != 0). Both are functions of registered state only; no combinational path from ENQ/DEQ.
- D_OUT = {head_A, head_B}, combinational from registers. Don't-care when EMPTY_N=0, but must hold the last head contents (no X).
- Latency: a word enqueued in cycle t on an empty channel appears at D_OUT in cycle t+1, provided the other channel is non-empty in t+1.
- Throughput: one word per channel per cycle with simultaneous ENQ and DEQ.
- Accepted enqueue: ENQ_x while FULL_N_x=1 writes D_x and increments count_x.
- Accepted dequeue: DEQ while EMPTY_N=1 decrements both counts and shifts tail->head in each channel where count was 2.
- Simultaneous ENQ_x and accepted DEQ on one channel:
  - count_x unchanged.
  - count=1: new word becomes head.
  - count=2: old tail becomes head, new word becomes tail.
- Full boundary: ENQ_x when FULL_N_x=0 is ignored (data dropped, count unchanged), even if DEQ is accepted in the same cycle. ERR is set.
- Empty boundary: DEQ when EMPTY_N=0 is ignored; neither channel changes, including the non-empty one. ERR is set. Any concurrent legal ENQ is still accepted.
- ERR: set on the cycle after a violation. Stays set until RST.
- Reset: RST=1 at a clock edge clears counts to 0 and head/tail registers to 0, regardless of in-flight ENQ/DEQ (RST wins).
  - After reset: FULL_N_A=1, FULL_N_B=1, EMPTY_N=0, D_OUT=0, ERR=0.
  - Words enqueued in the reset cycle are discarded.
- No wrap-around arithmetic beyond the 2-bit count saturating in {0,1,2}. Count value 3 is unreachable; an assertion flags it.

Test Plan:
- Reset, then check outputs -> FULL_N_A=1, FULL_N_B=1, EMPTY_N=0, D_OUT=0, ERR=0.
- iw=8. ENQ_A 0x11 at t0; ENQ_B 0x22 at t3 -> EMPTY_N=0 through t3, EMPTY_N=1 at t4 with D_OUT=0x1122. DEQ at t4 -> EMPTY_N=0 at t5.
- Fill A with 0xA0, 0xA1 and B with 0xB0 -> FULL_N_A=0, FULL_N_B=1. ENQ_A 0xA2 while full -> dropped, ERR=1 next cycle. Two DEQs after B gets 0xB1 -> D_OUT 0xA0B0 then 0xA1B1; 0xA2 never appears.
- Streaming: ENQ_A, ENQ_B and DEQ every cycle for 100 cycles, incrementing data -> D_OUT upper byte = lower byte = index, no stalls, counts stay at 1, ERR=0.
- DEQ with A holding 0x55 and B empty -> ignored, A still holds 0x55, ERR=1. Later ENQ_B 0x66 -> D_OUT=0x5566.
- Assert RST with both channels at count 2 and ENQ_A/ENQ_B/DEQ high -> next cycle all counts 0, EMPTY_N=0, FULL_N_A=1, FULL_N_B=1, ERR=0.
